countdown_timer: RTL and testbench
==================================

# countdown_timer

Three-digit BCD countdown timer, the decrementing counterpart of the stopwatch. Counts down from a loaded preset in 0.1 s steps (digits tens, ones, tenths), with start/pause/resume control. Asserts Done when the count reaches 00.0. It sits beside the stopwatch in the timing demo; its BCD digit outputs feed the board's seven-segment decoders at top level.

## Interface
- TICK_DIV, default 5_000_000: Clk cycles per 0.1 s tick; legal range ≥ 2.
- Clk  in  1  system clock; all state changes on rising edge.
- nReset  in  1  asynchronous, active-low reset.
- Load  in  1  single-cycle pulse; captures P2..P0 as the count.
- Start  in  1  single-cycle pulse; toggles run/pause, or acknowledges Done.
- P2, P1, P0  in  4 each  preset digits: tens, ones, tenths (BCD).
- D2, D1, D0  out  4 each  current count digits (BCD).
- Running  out  1  high while in RUN.
- Done  out  1  high while in DONE.

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low.
- States: IDLE, RUN, PAUSE, DONE.
- Reset values:
  - state IDLE
  - D2..D0 = 0
  - prescaler = 0
  - Running = 0, Done = 0
- Load has priority over Start and tick in every state:
  - digits take the preset values
  - prescaler clears
  - state goes to IDLE
- Preset digits above 9 are clamped to 9 on load.
- IDLE:
  - Start with count ≠ 000 → RUN.
  - Start with count = 000 is ignored.
- RUN:
  - The prescaler counts 0..TICK_DIV-1 and wraps.
  - tick = (prescaler == TICK_DIV-1).
  - On tick the count decrements by one tenth:
    - D0 = 0 wraps to 9 and borrows from D1.
    - D1 = 0 wraps to 9 and borrows from D2.
  - If the decremented value is 000, go to DONE on the same edge.
  - Start → PAUSE; the prescaler holds its value.
  - If Start and tick occur together, Start wins and no decrement happens.
- PAUSE:
  - Digits and prescaler are frozen.
  - Start → RUN; counting resumes from the held prescaler value.
- DONE:
  - Digits hold at 000.
  - Start → IDLE (acknowledge); Done drops.
- Borrow out of D2 cannot occur: 000 is always caught before wrap.

## Timing
- All outputs are registered.
- Running and Done change on the edge after the causing event.
- Load: preset visible on D2..D0 one cycle after the Load pulse.
- First tick after IDLE→RUN comes TICK_DIV cycles after the Start edge, because the prescaler starts from 0.
- Resume from PAUSE: the next tick arrives after (TICK_DIV − held prescaler) cycles.
- Done rises on the same edge that D2..D0 become 000.
- An asynchronous reset mid-count forces the reset values immediately; the preset is not retained.

## Structure
- Shared package `timer_pkg`:
  - state enum (IDLE, RUN, PAUSE, DONE)
  - 4-bit BCD digit type
  - constant BCD_MAX = 9
  - TICK_DIV default
- Sub-module `bcd_down_digit`:
  - inputs: Clk, nReset, load, load value, dec enable
  - outputs: digit, borrow
  - borrow = dec enable && digit == 0
  - instantiated three times, chained through borrow
- Top level contains the FSM, the prescaler, the zero detect and the preset clamp.

## Test plan
All scenarios use TICK_DIV = 4.
- Basic countdown:
  - Stimulus: load 0,0,3; Start.
  - Response: D0 reads 2, 1, 0 at 4, 8, 12 cycles after Start; Done rises with D0 = 0 at cycle 12; Running falls at the same edge.
- Borrow chain:
  - Stimulus: load 1,0,0; Start.
  - Response: after 4 cycles the digits read 0,9,9; after 8 more they read 0,9,7.
- Pause and resume:
  - Stimulus: load 0,0,2; Start; pulse Start 2 cycles later; wait 10 cycles; pulse Start.
  - Response: digits stay at 002 through the pause; D0 = 1 exactly 2 cycles after resume.
- Load priority and clamp:
  - Stimulus: in RUN, Load and Start in the same cycle with preset A,5,F.
  - Response: digits 9,5,9; state IDLE; Running = 0.
- Zero preset and acknowledge:
  - Stimulus: load 000; Start.
  - Response: stays in IDLE with Running = 0.
  - Stimulus: then complete a countdown and pulse Start in DONE.
  - Response: Done clears next cycle; digits stay 000.
- Asynchronous reset in RUN:
  - Stimulus: drop nReset between clock edges while in RUN.
  - Response: all outputs are 0 immediately; no tick occurs after release until a new Load and Start.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer and its digit cells.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX          = 4'd9;
    localparam int   TICK_DIV_DEFAULT = 5_000_000;

    // Non-BCD codes (A..F) collapse to the largest legal digit.
    function automatic bcd_t clamp_bcd(input bcd_t v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit that counts down, wrapping 0 -> 9 and signalling a borrow to the next digit.
module bcd_down_digit
    import timer_pkg::*;
(
    input  logic Clk,
    input  logic nReset,
    input  logic load,
    input  bcd_t load_value,
    input  logic dec_en,
    output bcd_t digit,
    output logic borrow
);

    bcd_t digit_reg;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            digit_reg <= '0;
        end else if (load) begin
            digit_reg <= load_value;
        end else if (dec_en) begin
            digit_reg <= (digit_reg == 4'd0) ? BCD_MAX : digit_reg - 4'd1;
        end
    end

    assign digit  = digit_reg;
    assign borrow = dec_en && (digit_reg == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// Three-digit BCD countdown timer (tens, ones, tenths) with start/pause/resume and Done.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic       Clk,
    input  logic       nReset,
    input  logic       Load,
    input  logic       Start,
    input  logic [3:0] P2,
    input  logic [3:0] P1,
    input  logic [3:0] P0,
    output logic [3:0] D2,
    output logic [3:0] D1,
    output logic [3:0] D0,
    output logic       Running,
    output logic       Done
);

    localparam int               PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    PSC_LAST = PW'(TICK_DIV - 1);

    state_t        state_reg;
    state_t        state_next;
    logic [PW-1:0] psc_reg;

    bcd_t preset [3];
    bcd_t digit  [3];
    logic borrow [3];
    logic dec_en [3];
    logic unused_borrow;

    logic tick;
    logic dec;
    logic count_zero;
    logic count_one;

    assign preset[0] = clamp_bcd(P0);
    assign preset[1] = clamp_bcd(P1);
    assign preset[2] = clamp_bcd(P2);

    // Start has priority over a coincident tick, and Load over both.
    assign tick = (state_reg == ST_RUN) && (psc_reg == PSC_LAST);
    assign dec  = tick && !Start && !Load;

    assign count_zero = (digit[2] == 4'd0) && (digit[1] == 4'd0) && (digit[0] == 4'd0);
    assign count_one  = (digit[2] == 4'd0) && (digit[1] == 4'd0) && (digit[0] == 4'd1);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_digit
            if (gi == 0) begin : g_lsd
                assign dec_en[gi] = dec;
            end else begin : g_chain
                assign dec_en[gi] = borrow[gi-1];
            end

            bcd_down_digit u_digit (
                .Clk        (Clk),
                .nReset     (nReset),
                .load       (Load),
                .load_value (preset[gi]),
                .dec_en     (dec_en[gi]),
                .digit      (digit[gi]),
                .borrow     (borrow[gi])
            );
        end
    endgenerate

    // 000 is caught before the tens digit could ever borrow.
    assign unused_borrow = borrow[2];

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            psc_reg <= '0;
        end else if (Load || state_reg == ST_IDLE) begin
            psc_reg <= '0;
        end else if (state_reg == ST_RUN && !Start) begin
            psc_reg <= tick ? '0 : psc_reg + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (Load) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state_reg)
                ST_IDLE:  if (Start && !count_zero) state_next = ST_RUN;
                ST_RUN: begin
                    if (Start)                  state_next = ST_PAUSE;
                    else if (tick && count_one) state_next = ST_DONE;
                end
                ST_PAUSE: if (Start) state_next = ST_RUN;
                ST_DONE:  if (Start) state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        Running = (state_reg == ST_RUN);
        Done    = (state_reg == ST_DONE);
    end

    assign D2 = digit[2];
    assign D1 = digit[1];
    assign D0 = digit[0];

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized and directed check of countdown_timer against an integer-tenths reference model.
module tb_countdown_timer;

    localparam int TD = 4;

    logic       Clk = 1'b0;
    logic       nReset;
    logic       Load, Start;
    logic [3:0] P2, P1, P0;
    logic [3:0] D2, D1, D0;
    logic       Running, Done;

    countdown_timer #(.TICK_DIV(TD)) dut (
        .Clk     (Clk),
        .nReset  (nReset),
        .Load    (Load),
        .Start   (Start),
        .P2      (P2),
        .P1      (P1),
        .P0      (P0),
        .D2      (D2),
        .D1      (D1),
        .D0      (D0),
        .Running (Running),
        .Done    (Done)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: count kept as a whole number of tenths, phase as cycles into the current tick.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    int m_count, m_phase, m_mode;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int clamp9(input logic [3:0] v);
        return (int'(v) > 9) ? 9 : int'(v);
    endfunction

    function automatic logic [31:0] model_vec();
        logic [3:0] t, o, f;
        t = 4'(m_count / 100);
        o = 4'((m_count / 10) % 10);
        f = 4'(m_count % 10);
        return {18'd0, t, o, f, m_mode == M_RUN, m_mode == M_DONE};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {18'd0, D2, D1, D0, Running, Done};
    endfunction

    task automatic model_reset();
        m_count = 0;
        m_phase = 0;
        m_mode  = M_IDLE;
    endtask

    task automatic model_step(input logic ld, input logic st, input logic [3:0] a, b, c);
        if (ld) begin
            m_count = clamp9(a) * 100 + clamp9(b) * 10 + clamp9(c);
            m_phase = 0;
            m_mode  = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            if (st && m_count != 0) m_mode = M_RUN;
            m_phase = 0;
        end else if (m_mode == M_RUN) begin
            if (st) begin
                m_mode = M_PAUSE;
            end else if (m_phase == TD - 1) begin
                m_phase = 0;
                m_count = m_count - 1;
                if (m_count == 0) m_mode = M_DONE;
            end else begin
                m_phase = m_phase + 1;
            end
        end else if (m_mode == M_PAUSE) begin
            if (st) m_mode = M_RUN;
        end else begin
            if (st) m_mode = M_IDLE;
        end
    endtask

    task automatic cyc(input logic ld, input logic st, input logic [3:0] a, b, c);
        Load  = ld;
        Start = st;
        P2 = a; P1 = b; P0 = c;
        @(posedge Clk);
        if (nReset) model_step(ld, st, a, b, c);
        #1;
        chk("cycle", dut_vec(), model_vec());
        if (ld || st)
            $display("txn t=%0t load=%0b start=%0b preset=%h%h%h -> count=%h%h%h run=%0b done=%0b",
                     $time, ld, st, a, b, c, D2, D1, D0, Running, Done);
        Load  = 1'b0;
        Start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    endtask

    initial begin
        nReset = 1'b0;
        Load = 1'b0; Start = 1'b0;
        P2 = 4'd0; P1 = 4'd0; P0 = 4'd0;
        model_reset();
        #12;
        chk("reset", dut_vec(), 32'd0);
        nReset = 1'b1;

        // Basic countdown from 003
        cyc(1'b1, 1'b0, 4'd0, 4'd0, 4'd3);
        cyc(1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
        idle(12);
        chk("basic_done", {27'd0, D0, Done, Running}, {27'd0, 4'd0, 1'b1, 1'b0});

        // Borrow chain from 100
        cyc(1'b1, 1'b0, 4'd1, 4'd0, 4'd0);
        cyc(1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
        idle(4);
        chk("borrow_099", {20'd0, D2, D1, D0}, 32'h099);
        idle(8);
        chk("borrow_097", {20'd0, D2, D1, D0}, 32'h097);

        // Pause with prescaler held at 2, resume ticks two cycles later
        cyc(1'b1, 1'b0, 4'd0, 4'd0, 4'd2);
        cyc(1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
        idle(2);
        cyc(1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
        idle(10);
        chk("pause_hold", {19'd0, D2, D1, D0, Running}, {19'd0, 12'h002, 1'b0});
        cyc(1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
        idle(1);
        chk("resume_early", {28'd0, D0}, 32'd2);
        idle(1);
        chk("resume_tick", {28'd0, D0}, 32'd1);

        // Load beats Start; presets clamp
        cyc(1'b1, 1'b0, 4'd0, 4'd0, 4'd5);
        cyc(1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
        idle(2);
        cyc(1'b1, 1'b1, 4'hA, 4'd5, 4'hF);
        chk("load_prio", {18'd0, D2, D1, D0, Running, Done}, {18'd0, 12'h959, 1'b0, 1'b0});

        // Zero preset ignored, then acknowledge Done
        cyc(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
        cyc(1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
        idle(2);
        chk("zero_start", {31'd0, Running}, 32'd0);
        cyc(1'b1, 1'b0, 4'd0, 4'd0, 4'd1);
        cyc(1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
        idle(4);
        chk("done_set", {31'd0, Done}, 32'd1);
        cyc(1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
        chk("done_ack", {19'd0, D2, D1, D0, Done}, 32'd0);

        // Start coinciding with a tick: pause wins, no decrement
        cyc(1'b1, 1'b0, 4'd0, 4'd0, 4'd3);
        cyc(1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
        idle(3);
        cyc(1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
        chk("start_vs_tick", {19'd0, D2, D1, D0, Running}, {19'd0, 12'h003, 1'b0});
        cyc(1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
        idle(1);
        chk("resume_at_last", {28'd0, D0}, 32'd2);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic       ld, st;
            logic [3:0] a, b, c;
            ld = ($urandom_range(0, 99) < 4);
            st = ($urandom_range(0, 99) < 7);
            a  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            b  = 4'($urandom_range(0, 15));
            c  = 4'($urandom_range(0, 15));
            cyc(ld, st, a, b, c);
        end

        // Asynchronous reset mid-count
        cyc(1'b1, 1'b0, 4'd0, 4'd1, 4'd5);
        cyc(1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
        idle(5);
        #3;
        nReset = 1'b0;
        #1;
        chk("async_rst", dut_vec(), 32'd0);
        model_reset();
        idle(2);
        #3;
        nReset = 1'b1;
        idle(10);
        chk("post_rst", dut_vec(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
